// File: rtl/ws_array_pkg.sv
// ws_array_pkg
// Shared types and constants for the weight-stationary array controller.
//   ws_state_t   : controller FSM state encoding
//   WS_N_DEFAULT : default array dimension
//   MEM_RD_LAT   : weight/activation SRAM read latency in cycles
//   PIPE_DEPTH   : psum pipeline depth through the array (one stage per row)
package ws_array_pkg;

  localparam int WS_N_DEFAULT     = 4;
  localparam int WS_K_MAX_DEFAULT = 16;
  localparam int MEM_RD_LAT       = 1;
  localparam int PIPE_DEPTH       = WS_N_DEFAULT;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ws_state_t;

endpackage

// File: rtl/ws_skew_gen.sv
// ws_skew_gen
// Turns the activation read-enable pulse train into the per-row feeder
// enables and the per-column "result at bottom" flags using one shift
// register; each output is a fixed tap.
//   clk, reset_n  : clock, async active-low reset
//   flush         : synchronous clear of the whole delay line
//   pulse_in      : activation memory read enable (one pulse per vector)
//   row_valid     : row r presents its element (read latency + r later)
//   out_col_valid : column c bottom psum is final (read latency + N + c later)
module ws_skew_gen
  import ws_array_pkg::*;
#(
  parameter int N = PIPE_DEPTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         pulse_in,
  output logic [N-1:0] row_valid,
  output logic [N-1:0] out_col_valid
);

  // sr[i] is pulse_in delayed by i+1 cycles.
  localparam int DEPTH = MEM_RD_LAT + 2 * N - 1;

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (flush) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], pulse_in};
    end
  end

  // Row r sees the element r cycles after row 0 (input skew); column c
  // result leaves the bottom after N psum stages plus c cycles of
  // horizontal activation propagation.
  for (genvar r = 0; r < N; r++) begin : g_tap
    assign row_valid[r]     = sr[MEM_RD_LAT - 1 + r];
    assign out_col_valid[r] = sr[MEM_RD_LAT - 1 + N + r];
  end

endmodule

// File: rtl/ws_array_controller.sv
// ws_array_controller
// Sequencer for an N x N weight-stationary PE grid: loads N weight rows,
// streams K activation vectors, drives feeder skew enables and flags
// finished column results.
//   clk, reset_n    : clock, async active-low reset
//   start, abort    : job request (IDLE only) / synchronous abort
//   num_vectors     : K for the job, clamped to K_MAX, latched at start
//   busy, done      : job in progress / one-cycle completion pulse
//   w_rd_en/addr    : weight SRAM read port
//   load_weight_row : one-hot per-row weight load strobe
//   act_rd_en/addr  : activation SRAM read port
//   row_valid       : per-row feeder enable
//   out_col_valid   : per-column finished result flag
//   out_vec_idx     : per-column vector index, column c at [c*KW +: KW]
//   dbg_state       : current FSM state
//
// Handshake: start and abort are level inputs sampled on each rising edge;
// every *_en / *_valid strobe is a single-cycle qualifier with no
// back-pressure, and an address or index is meaningful only while its
// strobe is high (it reads 0 otherwise).
module ws_array_controller
  import ws_array_pkg::*;
#(
  parameter int N     = PIPE_DEPTH,
  parameter int K_MAX = WS_K_MAX_DEFAULT,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [KW-1:0]        num_vectors,
  output logic                 busy,
  output logic                 done,
  output logic                 w_rd_en,
  output logic [$clog2(N)-1:0] w_rd_addr,
  output logic [N-1:0]         load_weight_row,
  output logic                 act_rd_en,
  output logic [KW-1:0]        act_rd_addr,
  output logic [N-1:0]         row_valid,
  output logic [N-1:0]         out_col_valid,
  output logic [N*KW-1:0]      out_vec_idx,
  output ws_state_t            dbg_state
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(3 * N + K_MAX + 3);

  ws_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;      // cnt holds the cycle number since start
  logic [KW-1:0] k_lat;
  logic [CW-1:0] done_cyc;

  logic          busy_d, done_d, w_rd_en_d, act_rd_en_d;
  logic [AW-1:0] w_rd_addr_d;
  logic [KW-1:0] act_rd_addr_d;
  logic [N-1:0]  load_weight_row_d;

  // With no vectors there is nothing to drain; a single DRAIN cycle only
  // covers the last weight row load.
  assign done_cyc = (k_lat == '0) ? CW'(N + 2) : CW'(3 * N + 1) + CW'(k_lat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      k_lat <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && start && !abort) begin
        k_lat <= (num_vectors > KW'(K_MAX)) ? KW'(K_MAX) : num_vectors;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nx = LOAD_W;
          cnt_nx   = CW'(1);
        end
      end
      LOAD_W: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(N)) begin
          state_nx = (k_lat == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(N) + CW'(k_lat)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        cnt_nx = cnt + CW'(1);
        if (cnt_nx == done_cyc) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  // Outputs are registered, so they are decoded from the next state/cycle.
  always_comb begin
    busy_d            = (state_nx != IDLE);
    done_d            = (state_nx == DONE);
    w_rd_en_d         = (state_nx == LOAD_W);
    act_rd_en_d       = (state_nx == STREAM);
    w_rd_addr_d       = w_rd_en_d ? AW'(cnt_nx - CW'(1)) : '0;
    act_rd_addr_d     = act_rd_en_d ? KW'(cnt_nx - CW'(N + 1)) : '0;
    load_weight_row_d = '0;
    // Weight data returns one cycle after the read; load the row it belongs to.
    if (w_rd_en && state_nx != IDLE) begin
      load_weight_row_d[w_rd_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      w_rd_en         <= 1'b0;
      w_rd_addr       <= '0;
      load_weight_row <= '0;
      act_rd_en       <= 1'b0;
      act_rd_addr     <= '0;
    end else begin
      busy            <= busy_d;
      done            <= done_d;
      w_rd_en         <= w_rd_en_d;
      w_rd_addr       <= w_rd_addr_d;
      load_weight_row <= load_weight_row_d;
      act_rd_en       <= act_rd_en_d;
      act_rd_addr     <= act_rd_addr_d;
    end
  end

  ws_skew_gen #(
    .N (N)
  ) u_skew (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (state_nx == IDLE),
    .pulse_in      (act_rd_en),
    .row_valid     (row_valid),
    .out_col_valid (out_col_valid)
  );

  // Column c result for vector k appears at cycle 2N+2+k+c.
  always_comb begin
    out_vec_idx = '0;
    for (int c = 0; c < N; c++) begin
      if (out_col_valid[c]) begin
        out_vec_idx[c*KW +: KW] = KW'(cnt - CW'(2 * N + 2 + c));
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ws_array_controller.sv
module tb_ws_array_controller;
  import ws_array_pkg::*;

  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int AW    = $clog2(N);

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            abort;
  logic [KW-1:0]   num_vectors;
  logic            busy;
  logic            done;
  logic            w_rd_en;
  logic [AW-1:0]   w_rd_addr;
  logic [N-1:0]    load_weight_row;
  logic            act_rd_en;
  logic [KW-1:0]   act_rd_addr;
  logic [N-1:0]    row_valid;
  logic [N-1:0]    out_col_valid;
  logic [N*KW-1:0] out_vec_idx;
  ws_state_t       dbg_state;

  always #5 clk = ~clk;

  ws_array_controller #(.N(N), .K_MAX(K_MAX)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .num_vectors     (num_vectors),
    .busy            (busy),
    .done            (done),
    .w_rd_en         (w_rd_en),
    .w_rd_addr       (w_rd_addr),
    .load_weight_row (load_weight_row),
    .act_rd_en       (act_rd_en),
    .act_rd_addr     (act_rd_addr),
    .row_valid       (row_valid),
    .out_col_valid   (out_col_valid),
    .out_vec_idx     (out_vec_idx),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [KW-1:0] exp_q[$];   // activation addresses still to be issued

  // Reference model: a job is just "cycles since acceptance" plus its K.
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_k      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int done_t(input int k);
    return (k == 0) ? N + 2 : 3 * N + k + 1;
  endfunction

  function automatic bit in_win(input int x, input int k);
    return (x >= 0) && (x < k);
  endfunction

  task automatic check_cycle();
    int        t;
    int        d;
    logic [N-1:0] e_lw;
    logic [N-1:0] e_rv;
    logic [N-1:0] e_cv;
    ws_state_t e_st;
    t    = m_t;
    d    = done_t(m_k);
    e_lw = '0;
    e_rv = '0;
    e_cv = '0;
    if (m_active) begin
      for (int r = 0; r < N; r++) begin
        e_lw[r] = (t == r + 2);
        e_rv[r] = in_win(t - N - 2 - r, m_k);
        e_cv[r] = in_win(t - 2 * N - 2 - r, m_k);
      end
    end
    if (!m_active)             e_st = IDLE;
    else if (t <= N)           e_st = LOAD_W;
    else if (t <= N + m_k)     e_st = STREAM;
    else if (t < d)            e_st = DRAIN;
    else                       e_st = DONE;

    check("busy",    64'(busy),    64'(m_active));
    check("done",    64'(done),    64'(m_active && t == d));
    check("w_rd_en", 64'(w_rd_en), 64'(m_active && t >= 1 && t <= N));
    if (m_active && t >= 1 && t <= N) check("w_rd_addr", 64'(w_rd_addr), 64'(t - 1));
    check("load_weight_row", 64'(load_weight_row), 64'(e_lw));
    check("act_rd_en", 64'(act_rd_en), 64'(m_active && t >= N + 1 && t <= N + m_k));
    if (act_rd_en === 1'b1) begin
      if (exp_q.size() == 0) check("act_rd_spurious", 64'(act_rd_en), 64'(0));
      else                   check("act_rd_addr", 64'(act_rd_addr), 64'(exp_q.pop_front()));
    end
    check("row_valid",     64'(row_valid),     64'(e_rv));
    check("out_col_valid", 64'(out_col_valid), 64'(e_cv));
    for (int c = 0; c < N; c++) begin
      if (e_cv[c]) check("out_vec_idx", 64'(out_vec_idx[c*KW +: KW]), 64'(t - 2 * N - 2 - c));
    end
    check("dbg_state", 64'(dbg_state), 64'(e_st));
  endtask

  task automatic model_step(input logic s, input logic a, input logic [KW-1:0] nv);
    if (m_active) begin
      if (a) begin
        m_active = 1'b0;
        exp_q.delete();
      end else if (m_t == done_t(m_k)) begin
        m_active = 1'b0;
      end else begin
        m_t++;
      end
    end else if (s && !a) begin
      m_active = 1'b1;
      m_t      = 1;
      m_k      = (int'(nv) > K_MAX) ? K_MAX : int'(nv);
      for (int i = 0; i < m_k; i++) exp_q.push_back(KW'(i));
    end
    if (!m_active) m_t = 0;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive just after the edge, check at the falling edge.
  task automatic cycle(input logic s, input logic a, input logic [KW-1:0] nv);
    start       = s;
    abort       = a;
    num_vectors = nv;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_step(s, a, nv);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, KW'($urandom_range(0, 31)));
  endtask

  task automatic finish_job();
    for (int i = 0; i < 200 && m_active; i++) cycle(1'b0, 1'b0, KW'($urandom_range(0, 31)));
    check("job_ends", 64'(busy), 64'(0));
  endtask

  task automatic run_job(input int k);
    cycle(1'b1, 1'b0, KW'(k));
    finish_job();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    num_vectors = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cycle();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Nominal K=3 job, then K=0, then clamped K=31
    run_job(3);
    idle(2);
    run_job(0);
    idle(1);
    run_job(31);
    idle(1);

    // start held high through a job; num_vectors wiggles while busy
    cycle(1'b1, 1'b0, KW'(3));
    for (int i = 0; i < 40 && m_active; i++) cycle(1'b1, 1'b0, KW'($urandom_range(0, 31)));
    cycle(1'b1, 1'b0, KW'(2));   // accepted in the single IDLE cycle
    finish_job();
    idle(1);

    // abort at cycle 7, then abort+start together in IDLE, then a full job
    cycle(1'b1, 1'b0, KW'(3));
    for (int i = 1; i < 7; i++) cycle(1'b0, 1'b0, KW'(3));
    cycle(1'b0, 1'b1, KW'(3));
    cycle(1'b0, 1'b0, KW'(3));
    cycle(1'b1, 1'b1, KW'(5));
    cycle(1'b0, 1'b1, KW'(5));
    run_job(3);
    idle(1);

    // async reset at cycle 9 of a job
    cycle(1'b1, 1'b0, KW'(3));
    for (int i = 1; i < 9; i++) cycle(1'b0, 1'b0, KW'(3));
    reset_n = 1'b0;
    #1;
    check("rst_busy",   64'(busy),            64'(0));
    check("rst_w_en",   64'(w_rd_en),         64'(0));
    check("rst_act_en", 64'(act_rd_en),       64'(0));
    check("rst_rowv",   64'(row_valid),       64'(0));
    check("rst_colv",   64'(out_col_valid),   64'(0));
    check("rst_lw",     64'(load_weight_row), 64'(0));
    check("rst_idx",    64'(out_vec_idx),     64'(0));
    m_active = 1'b0;
    m_t      = 0;
    exp_q.delete();
    @(negedge clk);
    check_cycle();
    reset_n = 1'b1;
    @(posedge clk);
    model_step(1'b0, 1'b0, num_vectors);
    #1;
    run_job(4);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic s;
      logic a;
      logic [KW-1:0] nv;
      s  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 40) == 0);
      nv = ($urandom_range(0, 5) == 0) ? KW'(0) : KW'($urandom_range(0, 31));
      cycle(s, a, nv);
    end
    finish_job();
    idle(2);
    check("act_q_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ws_array_controller.md
Name: ws_array_controller

Overview:
Sequencer for an N x N weight-stationary PE grid. It loads one weight row per cycle from weight memory, then streams K activation vectors from activation memory and drives the per-row skew enables for the input feeder. It also flags, per column, when a finished partial sum leaves the bottom of the array. It sits between the job/host interface and the array, its weight and activation SRAMs (1-cycle read latency) and the result writer.

Parameters:
N, 4, array dimension (rows = columns)
K_MAX, 16, maximum activation vectors per job
KW, $clog2(K_MAX+1), width of vector count and index

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  job request; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle
num_vectors  in  KW  K, vectors in job; latched at start
busy  out  1  high from the cycle after start acceptance through the DONE cycle
done  out  1  one-cycle pulse in DONE
w_rd_en  out  1  weight memory read enable
w_rd_addr  out  $clog2(N)  weight row address
load_weight_row  out  N  per-row load_weight to the PEs
act_rd_en  out  1  activation memory read enable
act_rd_addr  out  KW  activation vector address
row_valid  out  N  feeder enable: row r presents its element this cycle; the feeder drives 0 otherwise
out_col_valid  out  N  column c bottom psum_out holds a finished result
out_vec_idx  out  N*KW  per-column vector index of the result (column c at bits [c*KW +: KW])

Behaviour:
- Reset (async, reset_n=0): state IDLE, counters cleared, every output 0.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE. Cycle 0 is the IDLE cycle in which start=1 is sampled.
- Latching: K = min(num_vectors, K_MAX), captured at cycle 0.
- LOAD_W (cycles 1..N):
  - w_rd_en=1, w_rd_addr = cycle-1.
  - load_weight_row[r] is one-hot high at cycle r+2, aligned to the 1-cycle memory latency.
  - The last row load (cycle N+1) overlaps the first STREAM/DRAIN cycle.
- STREAM (cycles N+1..N+K):
  - act_rd_en=1, act_rd_addr = cycle-N-1.
  - Data for vector k arrives at cycle S+k, where S = N+2.
  - row_valid[r] is high at cycles S+k+r for k in 0..K-1.
- Outputs:
  - out_col_valid[c] is high at cycles 2N+2+k+c, and out_vec_idx for column c = k at those cycles.
  - This covers N PE stages of psum pipeline plus c stages of input propagation.
- DRAIN: from cycle N+K+1 until the last out_col_valid at cycle 3N+K.
- DONE: cycle 3N+K+1; done=1, busy=1.
- Return to IDLE: at cycle 3N+K+2. A start at that cycle is accepted, giving back-to-back jobs with one idle cycle.
- K=0: STREAM is skipped; one DRAIN cycle at N+1 covers the last weight load; DONE at N+2; no act_rd_en, row_valid or out_col_valid.
- start outside IDLE: ignored, with no effect on the running job.
- abort: from any non-IDLE state, all strobes go to 0 in the cycle after abort is sampled, and the FSM enters IDLE without a done pulse. abort in IDLE is ignored. abort and start in the same IDLE cycle: start is ignored.
- reset_n mid-job: immediate return to IDLE with outputs 0. Weight registers in the PEs are not guaranteed cleared by this block.
- Counters: a single cycle counter sized for 3N+K_MAX+2, plus a load-row counter. All outputs are registered except out_vec_idx, which is combinational from the cycle counter and column index.

Decomposition:
- Package ws_array_pkg holds:
  - state enum typedef {IDLE, LOAD_W, STREAM, DRAIN, DONE};
  - localparams for memory read latency (1) and pipeline depth (N).
- One natural sub-module, ws_skew_gen:
  - generates row_valid[N] and out_col_valid[N] from a stream-active pulse train;
  - uses shift-register delay lines, one tap per row/column.

Test Plan:
- N=4, K=3, start at cycle 0 -> w_rd_addr 0..3 at cycles 1..4; load_weight_row 0001,0010,0100,1000 at cycles 2..5; act_rd_addr 0..2 at cycles 5..7; row_valid[0] at 6..8, row_valid[3] at 9..11; out_col_valid[0] at 10..12, out_col_valid[3] at 13..15; done at 16; busy low at 17.
- Start held high through the job, then a second job -> second job accepted at cycle 17 (IDLE), first job timing unchanged.
- num_vectors=0 -> weights loaded, done at cycle 6 (N=4), act_rd_en never high.
- num_vectors=31 with K_MAX=16 -> exactly 16 act reads; done at 3N+16+1 = 29.
- abort at cycle 7 of the N=4, K=3 job -> all strobes 0 from cycle 8, state IDLE, no done; the next start runs a full normal job.
- reset_n low at cycle 9 -> all outputs 0 in the same cycle (async); after release, IDLE and start is accepted.
